instr_ram_arbiter: RTL

//  Shares the single-port instruction RAM (1-cycle read latency) between two requesters:

---
 rtl/instr_ram_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/instr_ram_arbiter.sv
// Two-port arbiter in front of the single-port instruction RAM: core fetch has fixed
// priority, the loader gets a one-access boost after waiting MAX_WAIT cycles.
module instr_ram_arbiter #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_req_i,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  output logic                    core_gnt_o,
  output logic                    core_rvalid_o,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  input  logic                    ld_req_i,
  input  logic                    ld_we_i,
  input  logic [DATA_WIDTH/8-1:0] ld_be_i,
  input  logic [ADDR_WIDTH-1:0]   ld_addr_i,
  input  logic [DATA_WIDTH-1:0]   ld_wdata_i,
  output logic                    ld_gnt_o,
  output logic                    ld_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ld_rdata_o,
  output logic                    ram_en_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_BOOST  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             valid_reg;
  logic             owner_reg;   // 1 = loader owns the outstanding access
  logic             core_gnt;
  logic             ld_gnt;

  // State register, wait counter and response tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_NORMAL;
      wait_cnt_reg <= '0;
      valid_reg    <= 1'b0;
      owner_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      valid_reg    <= core_gnt | ld_gnt;
      owner_reg    <= ld_gnt;
    end
  end

  // Next state: boost is entered in the same edge the counter saturates, so the
  // loader wins exactly MAX_WAIT cycles after it started waiting.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!ld_req_i || ld_gnt) begin
      wait_cnt_next = '0;
    end else if (wait_cnt_reg != MAX_WAIT_C) begin
      wait_cnt_next = wait_cnt_reg + CNT_W'(1);
    end

    state_next = state_reg;
    case (state_reg)
      ST_NORMAL: if (wait_cnt_next == MAX_WAIT_C) state_next = ST_BOOST;
      ST_BOOST:  if (ld_gnt || !ld_req_i)         state_next = ST_NORMAL;
      default:   state_next = ST_NORMAL;
    endcase
  end

  // Outputs: grants, RAM port mux and response routing
  always_comb begin
    core_gnt = 1'b0;
    ld_gnt   = 1'b0;
    if (!rst) begin
      if (state_reg == ST_BOOST && ld_req_i) begin
        ld_gnt = 1'b1;
      end else if (core_req_i) begin
        core_gnt = 1'b1;
      end else if (ld_req_i) begin
        ld_gnt = 1'b1;
      end
    end
  end

  assign core_gnt_o = core_gnt;
  assign ld_gnt_o   = ld_gnt;

  assign ram_en_o    = core_gnt | ld_gnt;
  assign ram_we_o    = ld_gnt & ld_we_i;
  assign ram_addr_o  = core_gnt ? core_addr_i : (ld_gnt ? ld_addr_i : '0);
  assign ram_wdata_o = ld_gnt ? ld_wdata_i : '0;

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_be
    assign ram_be_o[gi] = core_gnt | (ld_gnt & ld_be_i[gi]);
  end

  // Read data only reaches the port that owned the access; the other port sees 0
  assign core_rvalid_o = !rst && valid_reg && !owner_reg;
  assign ld_rvalid_o   = !rst && valid_reg &&  owner_reg;
  assign core_rdata_o  = core_rvalid_o ? ram_rdata_i : '0;
  assign ld_rdata_o    = ld_rvalid_o   ? ram_rdata_i : '0;

endmodule
